// File: rtl/slave_mem_readback.sv
// slave_mem_readback
// Reads the accelerator's result memory back through the slave memory port
// after the kernel finishes. One word-sized read is issued at a time, starting
// at base_addr. The bytes of each returned word go out, lowest byte first, on
// a valid/ready byte stream. A read that gets no M_DataRdy within TIMEOUT
// cycles ends the transfer with timeout_err set.
module slave_mem_readback #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 64,
  parameter int SIZE_W  = 7,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  byte_count,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              M_oe_ram,
  output logic              M_we_ram,
  output logic [ADDR_W-1:0] M_addr_ram,
  output logic [SIZE_W-1:0] M_data_ram_size,
  input  logic [DATA_W-1:0] M_Rdata_ram,
  input  logic              M_DataRdy,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0] BYTES_L      = LEN_W'(BYTES);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SHIFT,
    S_FIN
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ADDR_W-1:0]  r_curAddr;
  logic [LEN_W-1:0]   r_remaining;
  logic [DATA_W-1:0]  r_word;
  logic [LEN_W-1:0]   r_shiftLeft;
  logic [CNT_W-1:0]   r_waitCnt;
  logic               r_timeoutErr;
  logic [LEN_W-1:0]   w_n;
  logic [SIZE_W-1:0]  w_size;

  // Bytes covered by the current access: what is left, capped at one word.
  always_comb begin
    w_n    = (r_remaining > BYTES_L) ? BYTES_L : r_remaining;
    w_size = SIZE_W'({w_n, 3'b000});
  end

  // State register; reset forces IDLE from any state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and Moore outputs; address/size/data are zero when not in use.
  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    M_oe_ram   = 1'b0;
    byte_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        busy = 1'b1;
        if (r_remaining == '0) begin
          w_next = S_FIN;
        end else begin
          M_oe_ram = 1'b1;
          w_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        busy     = 1'b1;
        M_oe_ram = 1'b1;
        if (M_DataRdy) begin
          w_next = S_SHIFT;
        end else if (r_waitCnt == TIMEOUT_LAST) begin
          w_next = S_FIN;
        end
      end
      S_SHIFT: begin
        busy       = 1'b1;
        byte_valid = 1'b1;
        if (byte_ready && (r_shiftLeft == LEN_W'(1))) begin
          w_next = (r_remaining == w_n) ? S_FIN : S_REQ;
        end
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    M_addr_ram      = M_oe_ram ? r_curAddr : '0;
    M_data_ram_size = M_oe_ram ? w_size : '0;
    byte_out        = byte_valid ? r_word[7:0] : 8'h00;
  end

  assign M_we_ram    = 1'b0;
  assign timeout_err = r_timeoutErr;

  // Transfer bookkeeping: capture request, capture read word, shift bytes out, advance address.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_curAddr    <= '0;
      r_remaining  <= '0;
      r_word       <= '0;
      r_shiftLeft  <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_curAddr    <= base_addr;
        r_remaining  <= byte_count;
        r_timeoutErr <= 1'b0;
      end
      if (r_state == S_WAIT) begin
        if (M_DataRdy) begin
          r_word      <= M_Rdata_ram;
          r_shiftLeft <= w_n;
        end else if (r_waitCnt == TIMEOUT_LAST) begin
          r_timeoutErr <= 1'b1;
        end
      end
      if ((r_state == S_SHIFT) && byte_ready) begin
        r_word      <= r_word >> 8;
        r_shiftLeft <= r_shiftLeft - LEN_W'(1);
        if (r_shiftLeft == LEN_W'(1)) begin
          r_curAddr   <= r_curAddr + ADDR_W'(w_n);
          r_remaining <= r_remaining - w_n;
        end
      end
    end
  end

  // Per-access wait counter: zero in REQ, counts every cycle oe is high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_waitCnt <= '0;
    end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
      r_waitCnt <= r_waitCnt + CNT_W'(1);
    end else begin
      r_waitCnt <= '0;
    end
  end

endmodule

// File: tb/tb_slave_mem_readback.sv
// tb_slave_mem_readback
// Directed bench for slave_mem_readback. A slave memory model answers reads
// from a fixed byte image. A transfer-level model lists the accesses and the
// byte stream each transfer must produce, and a compare process checks the
// DUT against that list on every falling edge.
module tb_slave_mem_readback;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 64;
  localparam int SIZE_W  = 7;
  localparam int LEN_W   = 16;
  localparam int TIMEOUT = 255;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  byte_count = '0;
  logic              busy;
  logic              done;
  logic              timeout_err;
  logic              M_oe_ram;
  logic              M_we_ram;
  logic [ADDR_W-1:0] M_addr_ram;
  logic [SIZE_W-1:0] M_data_ram_size;
  logic [DATA_W-1:0] M_Rdata_ram = '0;
  logic              M_DataRdy = 1'b0;
  logic [7:0]        byte_out;
  logic              byte_valid;
  logic              byte_ready = 1'b1;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] mem [256];
  int expAcc[$];
  int expBytes[$];
  bit modelOn = 1'b0;
  bit slaveEnable = 1'b1;
  int slaveLat = 1;
  bit readyToggle = 1'b0;
  bit spurRdy = 1'b0;

  slave_mem_readback #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .byte_count(byte_count), .busy(busy), .done(done), .timeout_err(timeout_err),
    .M_oe_ram(M_oe_ram), .M_we_ram(M_we_ram), .M_addr_ram(M_addr_ram),
    .M_data_ram_size(M_data_ram_size), .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input logic [63:0] actual);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: got 0x%0h, expected nothing", name, actual);
  endtask

  // Slave memory and stream sink, driven just after each rising edge.
  initial begin
    int oeAge;
    logic [7:0] a;
    oeAge = 0;
    forever begin
      @(posedge clock);
      #1;
      if (M_oe_ram) begin
        oeAge++;
        if (slaveEnable && (oeAge == slaveLat + 1)) begin
          M_DataRdy = 1'b1;
          for (int k = 0; k < DATA_W / 8; k++) begin
            a = M_addr_ram + 8'(k);
            M_Rdata_ram[8*k +: 8] = mem[a];
          end
        end else begin
          M_DataRdy = 1'b0;
        end
      end else begin
        oeAge = 0;
        M_DataRdy = spurRdy;
        if (spurRdy) M_Rdata_ram = 64'hDEAD_BEEF_0BAD_F00D;
      end
      byte_ready = readyToggle ? ~byte_ready : 1'b1;
    end
  end

  // Compare process: accesses, address/size stability, byte stream order and hold.
  initial begin
    bit prevOe;
    bit holdPending;
    logic [7:0] heldByte;
    logic [ADDR_W-1:0] prevAddr;
    logic [SIZE_W-1:0] prevSize;
    int e;
    prevOe = 1'b0;
    holdPending = 1'b0;
    heldByte = '0;
    prevAddr = '0;
    prevSize = '0;
    forever begin
      @(negedge clock);
      if (modelOn && reset) begin
        if (M_oe_ram && !prevOe) begin
          if (expAcc.size() == 0) begin
            reportFail("unexpected access", {M_addr_ram, 1'b0, M_data_ram_size});
          end else begin
            e = expAcc.pop_front();
            checkOutput("access addr", M_addr_ram, 64'((e >> 8) & 255));
            checkOutput("access size", M_data_ram_size, 64'(e & 255));
            checkOutput("we low", M_we_ram, 0);
          end
        end
        if (M_oe_ram && prevOe) begin
          checkOutput("addr stable", M_addr_ram, prevAddr);
          checkOutput("size stable", M_data_ram_size, prevSize);
        end
        if (holdPending) begin
          checkOutput("valid held", byte_valid, 1);
          checkOutput("byte held", byte_out, heldByte);
        end
        if (byte_valid && byte_ready) begin
          if (expBytes.size() == 0) begin
            reportFail("extra byte", byte_out);
          end else begin
            e = expBytes.pop_front();
            checkOutput("stream byte", byte_out, 64'(e));
          end
        end
      end
      holdPending = byte_valid && !byte_ready;
      heldByte = byte_out;
      prevOe = M_oe_ram;
      prevAddr = M_addr_ram;
      prevSize = M_data_ram_size;
    end
  end

  task automatic applyStimulus(input logic [7:0] base, input int count);
    @(negedge clock);
    start = 1'b1;
    base_addr = base;
    byte_count = LEN_W'(count);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Builds the expected accesses/bytes, runs one transfer and checks its completion.
  task automatic runTransfer(input logic [7:0] base, input int count, input int lat,
                             input bit toggle, input bit rdyOn, input int expDone,
                             input bit expTimeout, input int glitchAt, input int expOe,
                             input int firstAddr, input int firstSize, input int firstByte);
    int cyc;
    int oeCycles;
    bit doneSeen;
    int n;
    logic [7:0] a;
    slaveLat = lat;
    readyToggle = toggle;
    slaveEnable = rdyOn;
    expAcc.delete();
    expBytes.delete();
    if (rdyOn) begin
      for (int off = 0; off < count; off += 8) begin
        n = (count - off > 8) ? 8 : count - off;
        a = base + 8'(off);
        expAcc.push_back(int'(a) * 256 + 8 * n);
      end
      for (int i = 0; i < count; i++) begin
        a = base + 8'(i);
        expBytes.push_back(int'(mem[a]));
      end
    end else if (count > 0) begin
      n = (count > 8) ? 8 : count;
      expAcc.push_back(int'(base) * 256 + 8 * n);
    end
    modelOn = 1'b1;
    applyStimulus(base, count);
    cyc = 0;
    oeCycles = 0;
    doneSeen = 1'b0;
    while (!doneSeen && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      if (M_oe_ram) oeCycles++;
      if (cyc == 1) begin
        checkOutput("busy after start", busy, 1);
        checkOutput("timeout_err cleared", timeout_err, 0);
        if (firstAddr >= 0) begin
          checkOutput("first addr literal", M_addr_ram, 64'(firstAddr));
          checkOutput("first size literal", M_data_ram_size, 64'(firstSize));
        end
      end
      if ((firstByte >= 0) && (cyc == 3)) begin
        checkOutput("first byte valid", byte_valid, 1);
        checkOutput("first byte literal", byte_out, 64'(firstByte));
      end
      if (cyc == glitchAt) begin
        start = 1'b1;
        base_addr = ~base;
        byte_count = 16'd5;
      end else if (cyc == glitchAt + 1) begin
        start = 1'b0;
      end
      if (done) doneSeen = 1'b1;
    end
    start = 1'b0;
    if (!doneSeen) begin
      reportFail("done never seen", cyc);
    end else begin
      if (expDone > 0) checkOutput("done cycle", cyc, expDone);
      checkOutput("busy low at done", busy, 0);
      checkOutput("timeout_err at done", timeout_err, expTimeout);
      if (expOe >= 0) checkOutput("oe cycles", oeCycles, expOe);
    end
    @(negedge clock);
    checkOutput("done one cycle", done, 0);
    checkOutput("timeout_err held", timeout_err, expTimeout);
    checkOutput("idle not busy", busy, 0);
    checkOutput("accesses left", expAcc.size(), 0);
    checkOutput("bytes left", expBytes.size(), 0);
    modelOn = 1'b0;
    readyToggle = 1'b0;
    spurRdy = 1'b0;
    expAcc.delete();
    expBytes.delete();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;

    #2;
    checkOutput("outputs in reset",
                {busy, done, timeout_err, M_oe_ram, M_we_ram, M_addr_ram, M_data_ram_size, byte_out, byte_valid}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("idle after reset", busy, 0);

    // Single full word, with a start pulse while busy that must be ignored.
    runTransfer(8'h10, 8, 1, 1'b0, 1'b1, 11, 1'b0, 3, 2, 16'h10, 64, 8'h4A);
    // Full word plus a partial 3-byte word.
    runTransfer(8'h00, 11, 1, 1'b0, 1'b1, 16, 1'b0, 0, 4, 0, 64, 8'h5A);
    // Slower slave.
    runTransfer(8'h40, 5, 3, 1'b0, 1'b1, 10, 1'b0, 0, 4, 16'h40, 40, -1);
    // No DataRdy ever: timeout after TIMEOUT cycles of oe.
    runTransfer(8'h30, 8, 1, 1'b0, 1'b0, 256, 1'b1, 0, 255, 16'h30, 64, -1);
    // Back-pressure plus spurious DataRdy while oe is low.
    spurRdy = 1'b1;
    runTransfer(8'h20, 11, 1, 1'b1, 1'b1, -1, 1'b0, 0, 4, -1, 0, -1);
    // Zero-length transfer with a start pulse while busy.
    runTransfer(8'h55, 0, 1, 1'b0, 1'b1, 2, 1'b0, 1, 0, -1, 0, -1);
    // Address wrap on the second access.
    runTransfer(8'hFC, 12, 1, 1'b0, 1'b1, 17, 1'b0, 0, 4, 16'hFC, 64, 8'hA6);

    // Reset in the middle of WAIT.
    slaveEnable = 1'b0;
    applyStimulus(8'h80, 8);
    repeat (4) @(negedge clock);
    checkOutput("oe before reset", M_oe_ram, 1);
    reset = 1'b0;
    #1;
    checkOutput("outputs on mid-wait reset",
                {busy, done, timeout_err, M_oe_ram, M_we_ram, M_addr_ram, M_data_ram_size, byte_out, byte_valid}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("idle after mid-wait reset", busy, 0);
    checkOutput("no oe after reset", M_oe_ram, 0);
    runTransfer(8'h08, 3, 1, 1'b0, 1'b1, 6, 1'b0, 0, 2, 16'h08, 24, 8'h52);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
